// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes and the
// select/control codes understood by the extender, ALU and datapath muxes.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11,
        StError    = 4'd12
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // Internal FSM-to-decoder request: force add, force sub, or decode funct fields.
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Combinational ALU operation decode from the FSM request and the instruction funct fields.
module multi_cycle_controller_alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = AluAdd;
        unique case (aluop)
            AluOpSub: alucontrol = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // instr[30] is part of the immediate for I-type, so only R-type subtracts
                    3'b000:  alucontrol = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alucontrol = AluSlt;
                    3'b100:  alucontrol = AluXor;
                    3'b110:  alucontrol = AluOr;
                    3'b111:  alucontrol = AluAnd;
                    default: alucontrol = AluAdd;
                endcase
            end
            default: alucontrol = AluAdd;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction, drives the
// datapath selects and write enables, flags unsupported opcodes and counts retirements.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic [2:0]       immsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       resultsrc,
    output logic [2:0]       alucontrol,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regwrite,
    output logic             memwrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d, state_out;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    logic       pcupdate, branch;
    logic       irwrite_s, regwrite_s, memwrite_s;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpLui:           state_d = StLui;
                    default:         state_d = StError;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StError:    state_d = StError;
            default:    state_d = StFetch;
        endcase
    end

    assign retire    = state_q inside {StMemWb, StMemWrite, StAluWb, StBranch};
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    assign illegal_d = illegal_q | (state_d == StError);

    // Under reset the outputs present FETCH selects regardless of the stale state register.
    assign state_out = reset_n ? state_q : StFetch;

    always_comb begin
        immsrc     = ImmI;
        alusrca    = SrcAPc;
        alusrcb    = SrcBRs2;
        resultsrc  = ResAluOut;
        aluop      = AluOpAdd;
        adrsrc     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        case (state_out)
            StFetch: begin
                irwrite_s = 1'b1;
                alusrcb   = SrcBFour;
                resultsrc = ResAluResult;
                pcupdate  = 1'b1;
            end
            StDecode: begin
                alusrca = SrcAOldPc;
                alusrcb = SrcBImm;
                immsrc  = ImmB;
            end
            StMemAdr: begin
                alusrca = SrcARs1;
                alusrcb = SrcBImm;
                immsrc  = op[5] ? ImmS : ImmI;
            end
            StMemRead: adrsrc = 1'b1;
            StMemWb: begin
                resultsrc  = ResData;
                regwrite_s = 1'b1;
            end
            StMemWrite: begin
                adrsrc     = 1'b1;
                memwrite_s = 1'b1;
            end
            StExecR: begin
                alusrca = SrcARs1;
                aluop   = AluOpFunct;
            end
            StExecI: begin
                alusrca = SrcARs1;
                alusrcb = SrcBImm;
                aluop   = AluOpFunct;
            end
            StAluWb: regwrite_s = 1'b1;
            StBranch: begin
                alusrca = SrcARs1;
                aluop   = AluOpSub;
                branch  = 1'b1;
            end
            StJal: begin
                alusrca  = SrcAOldPc;
                alusrcb  = SrcBFour;
                immsrc   = ImmJ;
                pcupdate = 1'b1;
            end
            StLui: begin
                alusrca = SrcAZero;
                alusrcb = SrcBImm;
                immsrc  = ImmU;
            end
            default: ;
        endcase
    end

    multi_cycle_controller_alu_decoder u_alu_decoder (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

    assign irwrite  = reset_n & irwrite_s;
    assign regwrite = reset_n & regwrite_s;
    assign memwrite = reset_n & memwrite_s;
    assign pcwrite  = reset_n & (pcupdate | (branch & (zero ^ funct3[0])));
    assign illegal  = illegal_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle control outputs;
// a negedge monitor pops and compares them against the controller.
module tb_multi_cycle_controller;

    localparam int CW = 5;

    typedef struct packed {
        logic          irwrite;
        logic          pcwrite;
        logic          regwrite;
        logic          memwrite;
        logic          adrsrc;
        logic          illegal;
        logic [2:0]    immsrc;
        logic [1:0]    a;
        logic [1:0]    b;
        logic [1:0]    res;
        logic [2:0]    alu;
        logic [CW-1:0] instret;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } item_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [6:0]    op = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          funct7b5 = 1'b0;
    logic          zero = 1'b0;
    logic [2:0]    immsrc, alucontrol;
    logic [1:0]    alusrca, alusrcb, resultsrc;
    logic          adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
    logic [CW-1:0] instret;

    multi_cycle_controller #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    item_t         sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    logic [CW-1:0] m_instret = '0;
    logic          m_illegal = 1'b0;

    function automatic exp_t actual();
        exp_t r;
        r.irwrite = irwrite;   r.pcwrite = pcwrite;   r.regwrite = regwrite;
        r.memwrite = memwrite; r.adrsrc = adrsrc;     r.illegal = illegal;
        r.immsrc = immsrc;     r.a = alusrca;         r.b = alusrcb;
        r.res = resultsrc;     r.alu = alucontrol;    r.instret = instret;
        return r;
    endfunction

    // Monitor: every clock with reset released is one observable control step.
    always @(negedge clk) begin
        exp_t  act, req;
        item_t it;
        act = actual();
        if (!reset_n) begin
            req = '0;
            req.b = 2'b10;
            req.res = 2'b10;
            req.illegal = act.illegal;
            req.instret = act.instret;
            n_checks++;
            if (act === req) n_pass++;
            else $display("FAIL reset_outputs: got %h want %h", act, req);
        end else begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: got step %h want no step", act);
            end else begin
                it = sb.pop_front();
                if (act === it.e) n_pass++;
                else $display("FAIL %s: got %h want %h", it.tag, act, it.e);
            end
        end
    end

    function automatic exp_t base();
        exp_t r = '0;
        r.instret = m_instret;
        r.illegal = m_illegal;
        return r;
    endfunction

    // Architectural ALU op for an EXEC step, straight from the RV32I funct3 table.
    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd4:    return 3'd4;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_instret = '0;
        m_illegal = 1'b0;
    endtask

    // abort_at < 0 runs to completion; otherwise reset after that many steps.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int abort_at);
        item_t seq[$];
        item_t it;
        exp_t  e;
        bit    err = 0;
        int    n;
        e = base(); e.irwrite = 1; e.pcwrite = 1; e.b = 2'b10; e.res = 2'b10;
        it.e = e; it.tag = "fetch"; seq.push_back(it);
        e = base(); e.a = 2'b01; e.b = 2'b01; e.immsrc = 3'b010;
        it.e = e; it.tag = "decode"; seq.push_back(it);
        case (o)
            7'b0000011, 7'b0100011: begin
                e = base(); e.a = 2'b10; e.b = 2'b01; e.immsrc = o[5] ? 3'b001 : 3'b000;
                it.e = e; it.tag = "memadr"; seq.push_back(it);
                if (o[5]) begin
                    e = base(); e.adrsrc = 1; e.memwrite = 1;
                    it.e = e; it.tag = "memwrite"; seq.push_back(it);
                end else begin
                    e = base(); e.adrsrc = 1;
                    it.e = e; it.tag = "memread"; seq.push_back(it);
                    e = base(); e.res = 2'b01; e.regwrite = 1;
                    it.e = e; it.tag = "memwb"; seq.push_back(it);
                end
            end
            7'b0110011, 7'b0010011: begin
                e = base(); e.a = 2'b10; e.b = o[5] ? 2'b00 : 2'b01; e.alu = alu_ref(o, f3, f7);
                it.e = e; it.tag = o[5] ? "exec_r" : "exec_i"; seq.push_back(it);
            end
            7'b1100011: begin
                e = base(); e.a = 2'b10; e.alu = 3'b001; e.pcwrite = z ^ f3[0];
                it.e = e; it.tag = "branch"; seq.push_back(it);
            end
            7'b1101111: begin
                e = base(); e.a = 2'b01; e.b = 2'b10; e.immsrc = 3'b011; e.pcwrite = 1;
                it.e = e; it.tag = "jal"; seq.push_back(it);
            end
            7'b0110111: begin
                e = base(); e.a = 2'b11; e.b = 2'b01; e.immsrc = 3'b100;
                it.e = e; it.tag = "lui"; seq.push_back(it);
            end
            default: begin
                err = 1;
                for (int i = 0; i < 3; i++) begin
                    e = base(); e.illegal = 1;
                    it.e = e; it.tag = "error"; seq.push_back(it);
                end
            end
        endcase
        if (o inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111}) begin
            e = base(); e.regwrite = 1;
            it.e = e; it.tag = "aluwb"; seq.push_back(it);
        end
        n = (!err && abort_at >= 0 && abort_at < seq.size()) ? abort_at : seq.size();
        for (int i = 0; i < n; i++) sb.push_back(seq[i]);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        repeat (n) @(posedge clk);
        #1;
        if (err || n < seq.size()) do_reset();
        else m_instret = m_instret + 1'b1;
    endtask

    task automatic run_random(input bit allow_faults);
        logic [6:0] ops [7];
        logic [6:0] o;
        int         r, ab;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111};
        r  = $urandom_range(0, 19);
        o  = ops[$urandom_range(0, 6)];
        ab = -1;
        if (allow_faults && r == 19) o = 7'($urandom_range(0, 127));
        if (allow_faults && r == 18) ab = $urandom_range(1, 4);
        run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ab);
    endtask

    initial begin
        do_reset();
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1);  // lw
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, -1);  // add
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1);  // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, -1);  // addi, instr[30]=1
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, -1);  // and
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, -1);  // slti
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1);  // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1);  // beq not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, -1);  // bne taken
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1);  // jal
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, -1);  // lui
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, -1);  // sw
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 4);   // lw aborted in MEMREAD->MEMWB
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1);  // illegal
        // Long fault-free run so the narrow counter wraps through all-ones to zero.
        for (int i = 0; i < 40; i++) run_random(1'b0);
        for (int i = 0; i < 150; i++) run_random(1'b1);
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
